csoc_cmd_parser: RTL and testbench

CSOC_CMD_PARSER -- requirements
Module: csoc_cmd_parser

---
 rtl/csoc_cmd_parser.sv | 270 +++++++++++++++++++++++++++
 tb/tb_csoc_cmd_parser.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csoc_cmd_parser.sv
// Byte-command parser that drives a CSoC's clock, reset, test pins and byte mailbox from a UART link.
// Every accepted command yields exactly one response byte; bytes arriving mid-command are dropped and flagged.
module csoc_cmd_parser #(
    parameter int CLK_DIV = 2,
    parameter int TIMEOUT = 50000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic [7:0] leds,
    output logic       csoc_clk,
    output logic       csoc_rstn,
    output logic       csoc_test_se,
    output logic       csoc_test_tm,
    input  logic       csoc_uart_write,
    output logic       csoc_uart_read,
    input  logic [7:0] csoc_data_i,
    output logic [7:0] csoc_data_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARG  = 3'd1,
        S_EXEC = 3'd2,
        S_STEP = 3'd3,
        S_SEND = 3'd4,
        S_WAIT = 3'd5
    } state_t;

    localparam logic [7:0]  OP_CTRL   = 8'h01;
    localparam logic [7:0]  OP_WRITE  = 8'h02;
    localparam logic [7:0]  OP_READ   = 8'h03;
    localparam logic [7:0]  OP_STATUS = 8'h04;
    localparam logic [7:0]  OP_STEP   = 8'h05;
    localparam logic [7:0]  RSP_ACK   = 8'h06;
    localparam logic [7:0]  RSP_NAK   = 8'h15;
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [27:0] TO_LAST   = 28'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  operand_q, operand_d;
    logic [3:0]  ctrl_q, ctrl_d;          // {run, test_tm, test_se, csoc_rstn}
    logic [7:0]  data_o_q, data_o_d;
    logic        uart_read_q, uart_read_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  cap_data_q, cap_data_d;
    logic        cap_valid_q, cap_valid_d;
    logic        ovr_q, ovr_d;
    logic [2:0]  sync_q, sync_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic        clk_q, clk_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic [27:0] to_cnt_q, to_cnt_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic        busy_seen_q, busy_seen_d;
    logic [7:0]  leds_q, leds_d;

    logic has_operand;
    logic cap_edge;
    logic clk_en;
    logic div_wrap;
    logic step_fall;
    logic step_done;
    logic to_expired;
    logic tx_fire;
    logic drop_state;

    assign has_operand = (rx_data == OP_CTRL) || (rx_data == OP_WRITE) || (rx_data == OP_STEP);
    assign cap_edge    = sync_q[1] & ~sync_q[2];
    assign clk_en      = ctrl_q[3] || (state_q == S_STEP);
    assign div_wrap    = clk_en && (div_cnt_q == DIV_LAST);
    // A high->low toggle closes one full period of the stepped clock.
    assign step_fall   = (state_q == S_STEP) && div_wrap && clk_q;
    assign step_done   = step_fall && (step_cnt_q == 8'd1);
    assign to_expired  = (state_q == S_ARG) && !new_rx_data && (to_cnt_q == TO_LAST);
    assign tx_fire     = (state_q == S_SEND) && !tx_busy;
    assign drop_state  = (state_q == S_EXEC) || (state_q == S_STEP) ||
                         (state_q == S_SEND) || (state_q == S_WAIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (new_rx_data) begin
                    state_d = has_operand ? S_ARG : S_EXEC;
                end
            end
            S_ARG: begin
                if (new_rx_data) begin
                    state_d = S_EXEC;
                end else if (to_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                // A free-running clock already provides edges, so STEP just acknowledges.
                if ((opcode_q == OP_STEP) && (operand_q != 8'd0) && !ctrl_q[3]) begin
                    state_d = S_STEP;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_STEP: begin
                if (step_done) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!tx_busy && (busy_seen_q || (wait_cnt_q == 2'd1))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        opcode_d    = opcode_q;
        operand_d   = operand_q;
        ctrl_d      = ctrl_q;
        data_o_d    = data_o_q;
        tx_data_d   = tx_data_q;
        cap_data_d  = cap_data_q;
        cap_valid_d = cap_valid_q;
        ovr_d       = ovr_q;
        step_cnt_d  = step_cnt_q;
        sync_d      = {sync_q[1:0], csoc_uart_write};
        uart_read_d = (state_q == S_EXEC) && (opcode_q == OP_WRITE);
        leds_d      = {ctrl_q[0], ctrl_q[1], ctrl_q[2], ctrl_q[3],
                       cap_valid_q, ovr_q, state_q[1:0]};
        to_cnt_d    = ((state_q == S_ARG) && !new_rx_data && !to_expired) ?
                      (to_cnt_q + 28'd1) : 28'd0;

        if ((state_q == S_IDLE) && new_rx_data) begin
            opcode_d = rx_data;
        end
        if ((state_q == S_ARG) && new_rx_data) begin
            operand_d = rx_data;
        end

        if (state_q == S_EXEC) begin
            case (opcode_q)
                OP_CTRL: begin
                    ctrl_d    = operand_q[3:0];
                    tx_data_d = RSP_ACK;
                end
                OP_WRITE: begin
                    data_o_d  = operand_q;
                    tx_data_d = RSP_ACK;
                end
                OP_READ: begin
                    tx_data_d   = cap_valid_q ? cap_data_q : 8'h00;
                    cap_valid_d = 1'b0;
                end
                OP_STATUS: begin
                    tx_data_d = {2'b00, ovr_q, cap_valid_q, ctrl_q[3], ctrl_q[2], ctrl_q[1], ctrl_q[0]};
                    ovr_d     = 1'b0;
                end
                OP_STEP: begin
                    step_cnt_d = operand_q;
                    tx_data_d  = RSP_ACK;
                end
                default: tx_data_d = RSP_NAK;
            endcase
        end

        // Ordered after the READ clear so a same-cycle capture survives it.
        if (cap_edge) begin
            cap_data_d  = csoc_data_i;
            cap_valid_d = 1'b1;
        end
        // A fresh drop outranks a STATUS clear: the new overrun has not been reported yet.
        if (new_rx_data && drop_state) begin
            ovr_d = 1'b1;
        end

        if (step_fall) begin
            step_cnt_d = step_cnt_q - 8'd1;
        end

        if (!clk_en) begin
            div_cnt_d = 16'd0;
            clk_d     = 1'b0;
        end else if (div_wrap) begin
            div_cnt_d = 16'd0;
            clk_d     = ~clk_q;
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
            clk_d     = clk_q;
        end

        if (state_q == S_WAIT) begin
            busy_seen_d = busy_seen_q | tx_busy;
            wait_cnt_d  = (wait_cnt_q == 2'd3) ? wait_cnt_q : (wait_cnt_q + 2'd1);
        end else begin
            busy_seen_d = 1'b0;
            wait_cnt_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            opcode_q    <= 8'h00;
            operand_q   <= 8'h00;
            ctrl_q      <= 4'h0;
            data_o_q    <= 8'h00;
            uart_read_q <= 1'b0;
            tx_data_q   <= 8'h00;
            cap_data_q  <= 8'h00;
            cap_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
            sync_q      <= 3'b000;
            div_cnt_q   <= 16'd0;
            clk_q       <= 1'b0;
            step_cnt_q  <= 8'd0;
            to_cnt_q    <= 28'd0;
            wait_cnt_q  <= 2'd0;
            busy_seen_q <= 1'b0;
            leds_q      <= 8'h00;
        end else begin
            opcode_q    <= opcode_d;
            operand_q   <= operand_d;
            ctrl_q      <= ctrl_d;
            data_o_q    <= data_o_d;
            uart_read_q <= uart_read_d;
            tx_data_q   <= tx_data_d;
            cap_data_q  <= cap_data_d;
            cap_valid_q <= cap_valid_d;
            ovr_q       <= ovr_d;
            sync_q      <= sync_d;
            div_cnt_q   <= div_cnt_d;
            clk_q       <= clk_d;
            step_cnt_q  <= step_cnt_d;
            to_cnt_q    <= to_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_seen_q <= busy_seen_d;
            leds_q      <= leds_d;
        end
    end

    // The request is gated by tx_busy directly so it can never fire into a busy transmitter.
    assign new_tx_data    = tx_fire;
    assign tx_data        = tx_data_q;
    assign leds           = leds_q;
    assign csoc_clk       = clk_q;
    assign csoc_rstn      = ctrl_q[0];
    assign csoc_test_se   = ctrl_q[1];
    assign csoc_test_tm   = ctrl_q[2];
    assign csoc_uart_read = uart_read_q;
    assign csoc_data_o    = data_o_q;

endmodule

// File: tb/tb_csoc_cmd_parser.sv
// Directed bench for csoc_cmd_parser: command vector table plus capture, overrun, timeout and reset sequences.
module tb_csoc_cmd_parser;

    localparam int CLK_DIV = 2;
    localparam int TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] rx_data = 8'h00;
    logic       new_rx_data = 1'b0;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy = 1'b0;
    logic [7:0] leds;
    logic       csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
    logic       csoc_uart_write = 1'b0;
    logic       csoc_uart_read;
    logic [7:0] csoc_data_i = 8'h00;
    logic [7:0] csoc_data_o;

    csoc_cmd_parser #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy), .leds(leds),
        .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn), .csoc_test_se(csoc_test_se),
        .csoc_test_tm(csoc_test_tm), .csoc_uart_write(csoc_uart_write),
        .csoc_uart_read(csoc_uart_read), .csoc_data_i(csoc_data_i), .csoc_data_o(csoc_data_o)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         rise_cnt = 0;
    int         rd_cnt = 0;
    int         busy_viol = 0;
    bit         busy_en = 1'b1;
    logic [7:0] resp_q[$];

    typedef struct {
        string      name;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] exp_resp;
        int         exp_edges;
        int         exp_rd;
        logic [7:0] exp_do;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic get_resp(input string nm, output logic [7:0] r);
        int n;
        n = 0;
        while (resp_q.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (resp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no response within 400 cycles, expected one", nm);
            r = 8'hxx;
        end else begin
            r = resp_q.pop_front();
        end
    endtask

    task automatic cmd(input string nm, input int nb, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] exp);
        logic [7:0] r;
        send_byte(b0);
        if (nb > 1) send_byte(b1);
        get_resp(nm, r);
        check({nm, " resp"}, {24'd0, r}, {24'd0, exp});
        repeat (10) @(negedge clk);
    endtask

    task automatic measure_half(output int cyc);
        logic prev;
        prev = csoc_clk;
        cyc  = 0;
        while (csoc_clk == prev && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Transmitter model: captures each request, then holds tx_busy for three cycles.
    initial begin
        int  busy_left;
        bit  pulse;
        busy_left = 0;
        forever begin
            @(negedge clk);
            pulse = new_tx_data;
            if (pulse) begin
                if (tx_busy) busy_viol++;
                resp_q.push_back(tx_data);
            end
            @(posedge clk);
            #1;
            if (pulse && busy_en) begin
                tx_busy   = 1'b1;
                busy_left = 3;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge csoc_clk);
        rise_cnt++;
    end

    initial forever begin
        @(negedge clk);
        if (csoc_uart_read) rd_cnt++;
    end

    initial begin
        logic [7:0] r;
        int         e0, d0, cyc, n;

        vecs[0] = '{"status_rst", 1, 8'h04, 8'h00, 8'h00, 0, 0, 8'h00};
        vecs[1] = '{"nak_7e",     1, 8'h7E, 8'h00, 8'h15, 0, 0, 8'h00};
        vecs[2] = '{"step_n0",    2, 8'h05, 8'h00, 8'h06, 0, 0, 8'h00};
        vecs[3] = '{"write_a5",   2, 8'h02, 8'hA5, 8'h06, 0, 1, 8'hA5};
        vecs[4] = '{"read_empty", 1, 8'h03, 8'h00, 8'h00, 0, 0, 8'hA5};
        vecs[5] = '{"step_n3",    2, 8'h05, 8'h03, 8'h06, 3, 0, 8'hA5};
        vecs[6] = '{"ctrl_07",    2, 8'h01, 8'h07, 8'h06, 0, 0, 8'hA5};
        vecs[7] = '{"status_07",  1, 8'h04, 8'h00, 8'h07, 0, 0, 8'hA5};

        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst leds", {24'd0, leds}, 32'h00);
        check("rst csoc_clk", {31'd0, csoc_clk}, 32'd0);
        check("rst csoc_rstn", {31'd0, csoc_rstn}, 32'd0);
        check("rst tx_data", {24'd0, tx_data}, 32'h00);
        check("rst new_tx_data", {31'd0, new_tx_data}, 32'd0);
        check("rst csoc_data_o", {24'd0, csoc_data_o}, 32'h00);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            e0 = rise_cnt;
            d0 = rd_cnt;
            cmd(vecs[i].name, vecs[i].nbytes, vecs[i].b0, vecs[i].b1, vecs[i].exp_resp);
            check({vecs[i].name, " edges"}, rise_cnt - e0, vecs[i].exp_edges);
            check({vecs[i].name, " uart_read"}, rd_cnt - d0, vecs[i].exp_rd);
            check({vecs[i].name, " data_o"}, {24'd0, csoc_data_o}, {24'd0, vecs[i].exp_do});
        end
        check("leds after ctrl 07", {24'd0, leds}, 32'hE0);
        check("csoc_clk low after step", {31'd0, csoc_clk}, 32'd0);

        // Capture through the synchroniser, then READ consumes it.
        csoc_data_i     = 8'h3C;
        csoc_uart_write = 1'b1;
        repeat (2) @(negedge clk);
        csoc_uart_write = 1'b0;
        repeat (6) @(negedge clk);
        check("leds cap_valid", {31'd0, leds[3]}, 32'd1);
        cmd("read_3c", 1, 8'h03, 8'h00, 8'h3C);
        cmd("read_again", 1, 8'h03, 8'h00, 8'h00);

        // Free-running clock.
        cmd("ctrl_0f", 2, 8'h01, 8'h0F, 8'h06);
        check("csoc_rstn", {31'd0, csoc_rstn}, 32'd1);
        check("csoc_test_se", {31'd0, csoc_test_se}, 32'd1);
        check("csoc_test_tm", {31'd0, csoc_test_tm}, 32'd1);
        check("leds[7:4]", {28'd0, leds[7:4]}, 32'hF);
        measure_half(cyc);
        measure_half(cyc);
        check("half period 1", cyc, CLK_DIV);
        measure_half(cyc);
        check("half period 2", cyc, CLK_DIV);
        cmd("step_while_run", 2, 8'h05, 8'h02, 8'h06);
        cmd("ctrl_01", 2, 8'h01, 8'h01, 8'h06);
        check("csoc_clk held low", {31'd0, csoc_clk}, 32'd0);

        // Byte landing while the response is in flight is dropped and flagged.
        send_byte(8'h7E);
        get_resp("nak_ovr", r);
        check("nak_ovr resp", {24'd0, r}, 32'h15);
        send_byte(8'h04);
        repeat (12) @(negedge clk);
        check("dropped byte no resp", resp_q.size(), 0);
        cmd("status_ovr", 1, 8'h04, 8'h00, 8'h21);
        busy_en = 1'b0;
        cmd("status_ovr_clr", 1, 8'h04, 8'h00, 8'h01);
        busy_en = 1'b1;

        // Operand arriving just inside the timeout is still accepted.
        send_byte(8'h02);
        repeat (35) @(negedge clk);
        cmd("write_late", 1, 8'hC3, 8'h00, 8'h06);
        check("write_late data_o", {24'd0, csoc_data_o}, 32'hC3);
        send_byte(8'h02);
        repeat (TIMEOUT + 5) @(negedge clk);
        check("timeout no resp", resp_q.size(), 0);
        cmd("status_after_to", 1, 8'h04, 8'h00, 8'h01);
        check("timeout data_o", {24'd0, csoc_data_o}, 32'hC3);

        // Reset in the middle of a long STEP.
        cmd("ctrl_07b", 2, 8'h01, 8'h07, 8'h06);
        send_byte(8'h05);
        send_byte(8'hFF);
        n = 0;
        while (csoc_clk !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("step clk high", {31'd0, csoc_clk}, 32'd1);
        rstn = 1'b0;
        #1;
        check("mid rst csoc_clk", {31'd0, csoc_clk}, 32'd0);
        check("mid rst csoc_rstn", {31'd0, csoc_rstn}, 32'd0);
        check("mid rst test_se", {31'd0, csoc_test_se}, 32'd0);
        check("mid rst test_tm", {31'd0, csoc_test_tm}, 32'd0);
        check("mid rst uart_read", {31'd0, csoc_uart_read}, 32'd0);
        check("mid rst data_o", {24'd0, csoc_data_o}, 32'h00);
        check("mid rst tx_data", {24'd0, tx_data}, 32'h00);
        check("mid rst new_tx_data", {31'd0, new_tx_data}, 32'd0);
        check("mid rst leds", {24'd0, leds}, 32'h00);
        repeat (3) @(negedge clk);
        check("no resp from aborted step", resp_q.size(), 0);
        rstn = 1'b1;
        cmd("status_first_cycle", 1, 8'h04, 8'h00, 8'h00);

        check("tx request while busy", busy_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
